uart_tx: RTL

UART transmitter that serialises parallel words into an asynchronous 8N1 line signal. It carries a small input FIFO so a producer can queue several words without waiting for each frame. It sits directly upstream of `uart_rx`: its `txif.sig` output drives the receiver's serial input, and the pair runs loop-back in the system bench. Frames are LSB-first: start bit (0), DATA_WIDTH data bits, optional parity bit, one stop bit (1).

---
 rtl/uart_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered UART transmitter, LSB-first 8N1 framing
// Define UART_TX_PARITY_EN to insert an even parity bit between the last data bit and the stop bit.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 19200,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] txif_data,
    input  logic                  txif_valid,
    output logic                  txif_ready,
    output logic                  txif_sig,
    output logic                  busy
);

    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W      = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int BIT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(PULSE_WIDTH - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full, empty, push, pop;

    state_t                state, state_n;
    logic [BAUD_W-1:0]     baud_cnt, baud_n;
    logic [BIT_W-1:0]      bit_cnt, bit_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic                  sig_q, sig_n;
    logic                  baud_done;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_n;
`endif

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign txif_ready = !full && !rst;
    assign push       = txif_valid && txif_ready;
    assign txif_sig   = sig_q;
    assign busy       = (state != IDLE);
    assign baud_done  = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= txif_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            sig_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            sig_q    <= sig_n;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt + 1'b1;
        bit_n    = bit_cnt;
        shift_n  = shift;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_n = parity_q;
`endif
        case (state)
            IDLE: begin
                baud_n = '0;
                pop    = !empty;
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        shift_n = shift >> 1;
                        bit_n   = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = IDLE;
                    pop     = !empty;
                end
            end
            default: begin
                baud_n  = '0;
                state_n = IDLE;
            end
        endcase

        // A pop from IDLE or the end of STOP starts the next frame with no gap
        if (pop) begin
            shift_n  = mem[rd_ptr];
            bit_n    = '0;
            baud_n   = '0;
            state_n  = START;
`ifdef UART_TX_PARITY_EN
            parity_n = ^mem[rd_ptr];
`endif
        end
    end

    always_comb begin
        sig_n = 1'b1;
        case (state_n)
            IDLE:    sig_n = 1'b1;
            START:   sig_n = 1'b0;
            DATA:    sig_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  sig_n = parity_n;
`endif
            STOP:    sig_n = 1'b1;
            default: sig_n = 1'b1;
        endcase
    end

endmodule
